// File: rtl/skinny_sbox8_ti3_reshare_pipelined.sv
// NSBOX parallel 3-share threshold SKINNY-128 8-bit S-boxes, 4 register stages,
// fresh randomness folded into every nonlinear gadget so shares are re-masked each stage.
module skinny_sbox8_ti3_reshare_pipelined #(
  parameter int NSBOX = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [8*NSBOX-1:0]   si0,
  input  logic [8*NSBOX-1:0]   si1,
  input  logic [8*NSBOX-1:0]   si2,
  input  logic [24*NSBOX-1:0]  r,
  output logic                 out_valid,
  output logic [8*NSBOX-1:0]   bo0,
  output logic [8*NSBOX-1:0]   bo1,
  output logic [8*NSBOX-1:0]   bo2
);

  // Each field holds the three shares {s2,s1,s0} of one bit.
  typedef struct packed {
    logic [2:0] a0, a1, a2, b5, b3, b1, b7, b2;
  } s1_t;

  typedef struct packed {
    logic [2:0] a0, a1, a2, a3, a4, b7, b3, b2;
  } s2_t;

  typedef struct packed {
    logic [2:0] a0, a1, a2, a3, a4, a5, a6, b2;
  } s3_t;

  // Shared NOR-XOR gadget; XOR of result shares = ~(a|b) ^ z, independent of rr.
  function automatic logic [2:0] g_fn(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] z, input logic [2:0] rr);
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] f;
    x = {a[2], a[1], ~a[0]};
    y = {b[2], b[1], ~b[0]};
    f[0] = (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ z[0] ^ rr[0] ^ rr[1];
    f[1] = (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ z[1] ^ rr[1] ^ rr[2];
    f[2] = (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ z[2] ^ rr[2] ^ rr[0];
    return f;
  endfunction

  function automatic logic [2:0] sh_fn(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [2:0] i);
    return {s2[i], s1[i], s0[i]};
  endfunction

  logic [3:0] vld_d;
  logic [3:0] vld_q;

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d = {vld_q[2:0], in_valid};
    end else begin
      vld_d = vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 4'd0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[3];

  for (genvar k = 0; k < NSBOX; k++) begin : g_lane
    logic [7:0]       x0, x1, x2;
    logic [23:0]      rk;
    logic [2:0]       a7_s;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    s3_t              s3_d, s3_q;
    logic [2:0][7:0]  o_d, o_q;

    assign x0 = si0[8*k +: 8];
    assign x1 = si1[8*k +: 8];
    assign x2 = si2[8*k +: 8];
    assign rk = r[24*k +: 24];

    // Operands a later stage needs are carried alongside so every stage sees one token.
    always_comb begin
      s1_d = s1_q;
      s2_d = s2_q;
      s3_d = s3_q;
      o_d  = o_q;
      a7_s = g_fn(s3_q.a4, s3_q.a5, s3_q.b2, rk[23:21]);
      if (en) begin
        s1_d.a0 = g_fn(sh_fn(x0, x1, x2, 3'd7), sh_fn(x0, x1, x2, 3'd6),
                       sh_fn(x0, x1, x2, 3'd4), rk[2:0]);
        s1_d.a1 = g_fn(sh_fn(x0, x1, x2, 3'd3), sh_fn(x0, x1, x2, 3'd2),
                       sh_fn(x0, x1, x2, 3'd0), rk[5:3]);
        s1_d.a2 = g_fn(sh_fn(x0, x1, x2, 3'd2), sh_fn(x0, x1, x2, 3'd1),
                       sh_fn(x0, x1, x2, 3'd6), rk[8:6]);
        s1_d.b5 = sh_fn(x0, x1, x2, 3'd5);
        s1_d.b3 = sh_fn(x0, x1, x2, 3'd3);
        s1_d.b1 = sh_fn(x0, x1, x2, 3'd1);
        s1_d.b7 = sh_fn(x0, x1, x2, 3'd7);
        s1_d.b2 = sh_fn(x0, x1, x2, 3'd2);

        s2_d.a3 = g_fn(s1_q.a0, s1_q.a1, s1_q.b5, rk[11:9]);
        s2_d.a4 = g_fn(s1_q.a1, s1_q.b3, s1_q.b1, rk[14:12]);
        s2_d.a0 = s1_q.a0;
        s2_d.a1 = s1_q.a1;
        s2_d.a2 = s1_q.a2;
        s2_d.b7 = s1_q.b7;
        s2_d.b3 = s1_q.b3;
        s2_d.b2 = s1_q.b2;

        s3_d.a5 = g_fn(s2_q.a2, s2_q.a3, s2_q.b7, rk[17:15]);
        s3_d.a6 = g_fn(s2_q.a3, s2_q.a0, s2_q.b3, rk[20:18]);
        s3_d.a0 = s2_q.a0;
        s3_d.a1 = s2_q.a1;
        s3_d.a2 = s2_q.a2;
        s3_d.a3 = s2_q.a3;
        s3_d.a4 = s2_q.a4;
        s3_d.b2 = s2_q.b2;

        for (int j = 0; j < 3; j++) begin
          o_d[j] = {s3_q.a3[j], s3_q.a0[j], s3_q.a1[j], s3_q.a6[j],
                    s3_q.a4[j], s3_q.a2[j], s3_q.a5[j], a7_s[j]};
        end
      end else begin
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        o_d  = o_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q <= '0;
        s2_q <= '0;
        s3_q <= '0;
        o_q  <= '0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
        o_q  <= o_d;
      end
    end

    assign bo0[8*k +: 8] = o_q[0];
    assign bo1[8*k +: 8] = o_q[1];
    assign bo2[8*k +: 8] = o_q[2];
  end

endmodule

// File: tb/tb_skinny_sbox8_ti3_reshare_pipelined.sv
// Directed and table-driven checks of the shared SKINNY S-box pipeline (1 lane and 16 lanes).
module tb_skinny_sbox8_ti3_reshare_pipelined;

  logic         clk = 1'b0;
  logic         rst, en, in_valid, out_valid;
  logic [7:0]   si0, si1, si2, bo0, bo1, bo2;
  logic [23:0]  r;
  logic         in_valid16, out_valid16;
  logic [127:0] t0, t1, t2, c0, c1, c2;
  logic [383:0] r16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]   mv;
  logic [7:0]   md [4];
  logic [3:0]   mv16;
  logic [127:0] md16 [4];

  always #5 clk = ~clk;

  skinny_sbox8_ti3_reshare_pipelined #(.NSBOX(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .si0(si0), .si1(si1), .si2(si2), .r(r),
    .out_valid(out_valid), .bo0(bo0), .bo1(bo1), .bo2(bo2)
  );

  skinny_sbox8_ti3_reshare_pipelined #(.NSBOX(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid16),
    .si0(t0), .si1(t1), .si2(t2), .r(r16),
    .out_valid(out_valid16), .bo0(c0), .bo1(c1), .bo2(c2)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Unmasked reference straight from the NOR/XOR network and output bit map.
  function automatic logic [7:0] s8_ref(input logic [7:0] b);
    logic [7:0] a;
    a[0] = ~(b[7] | b[6]) ^ b[4];
    a[1] = ~(b[3] | b[2]) ^ b[0];
    a[2] = ~(b[2] | b[1]) ^ b[6];
    a[3] = ~(a[0] | a[1]) ^ b[5];
    a[4] = ~(a[1] | b[3]) ^ b[1];
    a[5] = ~(a[2] | a[3]) ^ b[7];
    a[6] = ~(a[3] | a[0]) ^ b[3];
    a[7] = ~(a[4] | a[5]) ^ b[2];
    return {a[3], a[0], a[1], a[6], a[4], a[2], a[5], a[7]};
  endfunction

  // One clock of the single-lane DUT; called and returns at a negedge.
  task automatic cycle(input logic rs, input logic e, input logic v,
                       input logic [7:0] val, input logic [7:0] exp_s, input logic zr);
    logic [31:0] rnd;
    rst = rs;
    en = e;
    in_valid = v;
    in_valid16 = 1'b0;
    if (zr) begin
      si1 = 8'h00;
      si2 = 8'h00;
      r   = 24'h0;
    end else begin
      rnd = $urandom;
      si1 = rnd[7:0];
      si2 = rnd[15:8];
      rnd = $urandom;
      r   = rnd[23:0];
    end
    si0 = val ^ si1 ^ si2;
    @(posedge clk);
    if (rs) begin
      mv = 4'd0;
    end else if (e) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = v;
      md[0] = exp_s;
    end
    @(negedge clk);
    check_eq("out_valid", 128'(out_valid), 128'(mv[3]));
    if (mv[3]) check_eq("sbox_xor", 128'(bo0 ^ bo1 ^ bo2), 128'(md[3]));
    if (rs) begin
      check_eq("rst_bo0", 128'(bo0), 128'd0);
      check_eq("rst_bo1", 128'(bo1), 128'd0);
      check_eq("rst_bo2", 128'(bo2), 128'd0);
    end
  endtask

  // One clock of the 16-lane DUT with fresh shares and randomness.
  task automatic cycle16(input logic v, input logic [127:0] val);
    logic [127:0] exp_s;
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    in_valid16 = v;
    for (int w = 0; w < 4; w++) begin
      t1[32*w +: 32] = $urandom;
      t2[32*w +: 32] = $urandom;
    end
    for (int w = 0; w < 12; w++) r16[32*w +: 32] = $urandom;
    t0 = val ^ t1 ^ t2;
    for (int k = 0; k < 16; k++) exp_s[8*k +: 8] = s8_ref(val[8*k +: 8]);
    @(posedge clk);
    for (int i = 3; i > 0; i--) begin
      mv16[i] = mv16[i-1];
      md16[i] = md16[i-1];
    end
    mv16[0] = v;
    md16[0] = exp_s;
    @(negedge clk);
    check_eq("out_valid16", 128'(out_valid16), 128'(mv16[3]));
    if (mv16[3]) check_eq("sbox16_xor", c0 ^ c1 ^ c2, md16[3]);
  endtask

  logic [7:0]   dir_in  [5] = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hFF};
  logic [7:0]   dir_out [5] = '{8'h65, 8'h4C, 8'h6A, 8'h36, 8'hFF};
  logic [3:0]   bub = 4'b1001;
  logic [127:0] tok;

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; si0 = 8'h00; si1 = 8'h00; si2 = 8'h00; r = 24'h0;
    in_valid16 = 1'b0; t0 = '0; t1 = '0; t2 = '0; r16 = '0;
    mv = 4'd0; mv16 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      md[i] = 8'h00;
      md16[i] = 128'd0;
    end
    @(negedge clk);
    // Reset with en low still clears everything.
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Single all-zero token, r=0: valid exactly 4 cycles later, XOR 0x65.
    cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h65, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);

    // Hand-computed table values, back-to-back with random splits.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, dir_in[i], dir_out[i], 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // All 256 inputs, one per cycle.
    for (int i = 0; i < 256; i++) cycle(1'b0, 1'b1, 1'b1, 8'(i), s8_ref(8'(i)), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random stalls mid-stream; a token is only consumed on an enabled cycle.
    begin
      int i;
      logic e;
      i = 0;
      while (i < 40) begin
        e = ($urandom_range(3, 0) != 0);
        cycle(1'b0, e, 1'b1, 8'(i * 7 + 3), s8_ref(8'(i * 7 + 3)), 1'b0);
        if (e) i++;
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Bubble pattern 1,0,0,1.
    for (int i = 3; i >= 0; i--) cycle(1'b0, 1'b1, bub[i], 8'h5A, s8_ref(8'h5A), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset with 3 tokens in flight; none may emerge afterwards.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 8'(i + 16), s8_ref(8'(i + 16)), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h33, s8_ref(8'h33), 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Sixteen lanes: a ramp token, random tokens, and one token repeated under new r.
    for (int k = 0; k < 16; k++) tok[8*k +: 8] = 8'(k * 17);
    cycle16(1'b1, tok);
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 4; w++) tok[32*w +: 32] = $urandom;
      cycle16(1'b1, tok);
    end
    cycle16(1'b1, tok);
    for (int i = 0; i < 5; i++) cycle16(1'b0, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
